uart_cfg_ctrl: RTL and testbench
================================

UART_CFG_CTRL -- requirements
Module: uart_cfg_ctrl

Interface
REQ-001 The block SHALL have parameter SettleCycles, default 2: consecutive cycles with Tx and Rx both idle required before a new configuration is applied (legal range 1-255).
REQ-002 The block SHALL have parameter TimeoutCycles, default 1024: maximum cycles spent in DRAIN; 0 disables the timeout.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_ni, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port cfg_valid_i, input, 1 bit: configuration request valid.
REQ-006 The block SHALL have port cfg_ready_o, output, 1 bit: the block accepts a request.
REQ-007 The block SHALL have port cfg_data_bits_i, input, 4 bits: requested data bit count, legal 5-8.
REQ-008 The block SHALL have port cfg_stop_bits_i, input, 2 bits: requested stop bit count, legal 1-3.
REQ-009 The block SHALL have port cfg_parity_en_i, input, 1 bit: parity enable request.
REQ-010 The block SHALL have port cfg_done_o, output, 1 bit: one-cycle pulse that completes a request.
REQ-011 The block SHALL have port cfg_err_o, output, 1 bit: request status, valid only while cfg_done_o=1 (1 = rejected or timed out).
REQ-012 The block SHALL have port tx_busy_i, input, 1 bit: the UART transmitter is mid-frame.
REQ-013 The block SHALL have port rx_busy_i, input, 1 bit: the UART receiver is mid-frame.
REQ-014 The block SHALL have port tx_hold_o, output, 1 bit: the Tx must not start a new frame.
REQ-015 The block SHALL have port uart_cfg_o, output, 5 bits: the configuration word to Tx/Rx.
REQ-016 The block SHALL have port cfg_update_o, output, 1 bit: one-cycle pulse marking a newly applied uart_cfg_o.

Function
REQ-017 The block SHALL encode uart_cfg_o as {data_bits-5 [4:3], stop_bits-1 [2:1], parity_en [0]}.
REQ-018 The block SHALL implement the states IDLE, CHECK, DRAIN, APPLY and RESP.
REQ-019 The block SHALL drive cfg_ready_o=1 only in IDLE.
REQ-020 The block SHALL capture the request fields into registers on the cycle where cfg_valid_i=1 and cfg_ready_o=1, then move to CHECK.
REQ-021 In CHECK, for a request with data bits outside 5-8 or stop bits of 0, the block SHALL go to RESP with err=1 and leave uart_cfg_o unchanged.
REQ-022 In CHECK, for a legal request whose encoding equals the current uart_cfg_o, the block SHALL go to RESP with err=0 and SHALL NOT pulse cfg_update_o.
REQ-023 In CHECK, for any other legal request, the block SHALL go to DRAIN and clear the settle and timeout counters.
REQ-024 In DRAIN, the settle counter SHALL increment on each cycle with tx_busy_i=0 and rx_busy_i=0, and SHALL clear to 0 on any cycle where either input is 1.
REQ-025 In DRAIN, the timeout counter SHALL increment every cycle.
REQ-026 Counter widths SHALL be $clog2(param+1), and both counters SHALL saturate rather than wrap.
REQ-027 The block SHALL leave DRAIN for APPLY when the settle count reaches SettleCycles.
REQ-028 When TimeoutCycles is nonzero, the block SHALL leave DRAIN for RESP with err=1 when the timeout count reaches TimeoutCycles, with uart_cfg_o unchanged.
REQ-029 When settle and timeout complete in the same cycle, the block SHALL take APPLY (settle wins).
REQ-030 The block SHALL load uart_cfg_o on the DRAIN->APPLY transition, so the new value is visible in the APPLY cycle.
REQ-031 The block SHALL assert cfg_update_o for exactly the APPLY cycle, then go to RESP with err=0.
REQ-032 The block SHALL assert tx_hold_o exactly while in DRAIN or APPLY.
REQ-033 The block SHALL assert cfg_done_o for the single RESP cycle, with cfg_err_o valid in that cycle, then return to IDLE.
REQ-034 The block SHALL ignore request inputs while not in IDLE.
REQ-035 A request SHALL be acceptable again in the IDLE cycle that follows RESP.
REQ-036 With idle Tx/Rx and SettleCycles=2, latency from acceptance at cycle N SHALL be: DRAIN N+2..N+3, APPLY N+4, cfg_done_o at N+5.
REQ-037 For a rejected or identical request accepted at cycle N, cfg_done_o SHALL assert at N+2.

Reset
REQ-038 While rst_ni=0 at a clock edge, the state SHALL become IDLE, both counters 0, uart_cfg_o=5'b11000 (8N1), and tx_hold_o, cfg_update_o, cfg_done_o and cfg_err_o 0.
REQ-039 cfg_ready_o SHALL be 1 after reset.
REQ-040 Reset asserted mid-operation (any state) SHALL abandon the request, produce no cfg_done_o, and restore 8N1.

Verification
REQ-041 The bench SHALL check: after reset -> uart_cfg_o=5'b11000, cfg_ready_o=1, all other outputs 0.
REQ-042 The bench SHALL check: request 7 data, 2 stop, parity, with idle busy inputs -> uart_cfg_o=5'b10011 and cfg_update_o=1 at N+4, cfg_done_o=1 with cfg_err_o=0 at N+5.
REQ-043 The bench SHALL check: request data=4 or stop=0 -> cfg_done_o=1 with cfg_err_o=1 at N+2, no cfg_update_o, and tx_hold_o never asserted.
REQ-044 The bench SHALL check: tx_busy_i high for 10 cycles, then rx_busy_i high 1 cycle after a single idle cycle -> the settle counter restarts and APPLY occurs after 2 consecutive idle cycles.
REQ-045 The bench SHALL check: TimeoutCycles=16 with tx_busy_i held 1 -> cfg_done_o=1 with cfg_err_o=1 after 16 DRAIN cycles, uart_cfg_o unchanged, tx_hold_o released.
REQ-046 The bench SHALL check: rst_ni=0 during DRAIN -> the next cycle shows IDLE, 8N1, tx_hold_o=0, and no cfg_done_o.

Source files
------------

// File: rtl/uart_cfg_ctrl.sv
// UART line-configuration controller. It validates a request, waits for Tx/Rx
// to go quiet, swaps the frame format atomically and reports completion.
module uart_cfg_ctrl #(
  parameter int SettleCycles  = 2,
  parameter int TimeoutCycles = 1024
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       cfg_valid_i,
  output logic       cfg_ready_o,
  input  logic [3:0] cfg_data_bits_i,
  input  logic [1:0] cfg_stop_bits_i,
  input  logic       cfg_parity_en_i,
  output logic       cfg_done_o,
  output logic       cfg_err_o,
  input  logic       tx_busy_i,
  input  logic       rx_busy_i,
  output logic       tx_hold_o,
  output logic [4:0] uart_cfg_o,
  output logic       cfg_update_o
);

  localparam int              SetW       = $clog2(SettleCycles + 1);
  localparam int              ToW        = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam bit              TimeoutEn  = (TimeoutCycles > 0);
  localparam logic [SetW-1:0] SettleTgt  = SetW'(SettleCycles);
  localparam logic [ToW-1:0]  TimeoutTgt = ToW'(TimeoutCycles);
  localparam logic [4:0]      Cfg8N1     = 5'b11000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_DRAIN = 3'd2,
    ST_APPLY = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  function automatic logic req_legal(input logic [3:0] d, input logic [1:0] s);
    return (d >= 4'd5) && (d <= 4'd8) && (s != 2'd0);
  endfunction

  function automatic logic [4:0] cfg_encode(input logic [3:0] d, input logic [1:0] s,
                                            input logic p);
    logic [1:0] dm;
    logic [1:0] sm;
    dm = 2'(d - 4'd5);
    sm = s - 2'd1;
    return {dm, sm, p};
  endfunction

  state_e          state_q, state_d;
  logic [3:0]      data_q, data_d;
  logic [1:0]      stop_q, stop_d;
  logic            par_q, par_d;
  logic [SetW-1:0] settle_q, settle_d;
  logic [ToW-1:0]  timeout_q, timeout_d;
  logic [4:0]      uart_cfg_q, uart_cfg_d;
  logic            ready_q, ready_d;
  logic            hold_q, hold_d;
  logic            update_q, update_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            resp_err_s;

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    stop_d     = stop_q;
    par_d      = par_q;
    settle_d   = settle_q;
    timeout_d  = timeout_q;
    uart_cfg_d = uart_cfg_q;
    resp_err_s = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cfg_valid_i) begin
          data_d  = cfg_data_bits_i;
          stop_d  = cfg_stop_bits_i;
          par_d   = cfg_parity_en_i;
          state_d = ST_CHECK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (!req_legal(data_q, stop_q)) begin
          state_d    = ST_RESP;
          resp_err_s = 1'b1;
        end else if (cfg_encode(data_q, stop_q, par_q) == uart_cfg_q) begin
          state_d    = ST_RESP;
          resp_err_s = 1'b0;
        end else begin
          state_d   = ST_DRAIN;
          settle_d  = '0;
          timeout_d = '0;
        end
      end
      ST_DRAIN: begin
        // Both counters saturate at all-ones instead of wrapping.
        settle_d  = (tx_busy_i || rx_busy_i) ? '0 :
                    ((settle_q == {SetW{1'b1}}) ? settle_q : settle_q + SetW'(1));
        timeout_d = (timeout_q == {ToW{1'b1}}) ? timeout_q : timeout_q + ToW'(1);
        if (settle_d == SettleTgt) begin
          state_d    = ST_APPLY;
          uart_cfg_d = cfg_encode(data_q, stop_q, par_q);
        end else if (TimeoutEn && (timeout_d == TimeoutTgt)) begin
          state_d    = ST_RESP;
          resp_err_s = 1'b1;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_APPLY: begin
        state_d    = ST_RESP;
        resp_err_s = 1'b0;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ready_d  = (state_d == ST_IDLE);
    hold_d   = (state_d == ST_DRAIN) || (state_d == ST_APPLY);
    update_d = (state_d == ST_APPLY);
    done_d   = (state_d == ST_RESP);
    err_d    = (state_d == ST_RESP) ? resp_err_s : 1'b0;
  end

  // State and output registers with synchronous reset to 8N1.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      data_q     <= 4'd0;
      stop_q     <= 2'd0;
      par_q      <= 1'b0;
      settle_q   <= '0;
      timeout_q  <= '0;
      uart_cfg_q <= Cfg8N1;
      ready_q    <= 1'b1;
      hold_q     <= 1'b0;
      update_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      stop_q     <= stop_d;
      par_q      <= par_d;
      settle_q   <= settle_d;
      timeout_q  <= timeout_d;
      uart_cfg_q <= uart_cfg_d;
      ready_q    <= ready_d;
      hold_q     <= hold_d;
      update_q   <= update_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign cfg_ready_o  = ready_q;
  assign tx_hold_o    = hold_q;
  assign cfg_update_o = update_q;
  assign cfg_done_o   = done_q;
  assign cfg_err_o    = err_q;
  assign uart_cfg_o   = uart_cfg_q;

endmodule

// File: tb/tb_uart_cfg_ctrl.sv
// Directed bench for uart_cfg_ctrl: expected responses are queued at request
// time and checked against cfg_done_o/cfg_err_o/uart_cfg_o when they appear.
module tb_uart_cfg_ctrl;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       cfg_valid_i;
  logic       cfg_ready_o;
  logic [3:0] cfg_data_bits_i;
  logic [1:0] cfg_stop_bits_i;
  logic       cfg_parity_en_i;
  logic       cfg_done_o;
  logic       cfg_err_o;
  logic       tx_busy_i;
  logic       rx_busy_i;
  logic       tx_hold_o;
  logic [4:0] uart_cfg_o;
  logic       cfg_update_o;

  typedef struct packed {
    logic       err;
    logic [4:0] cfg;
  } resp_t;

  resp_t exp_q[$];
  int    vectors     = 0;
  int    miscompares = 0;

  always #5 clk = ~clk;

  uart_cfg_ctrl #(.SettleCycles(2), .TimeoutCycles(16)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .cfg_valid_i    (cfg_valid_i),
    .cfg_ready_o    (cfg_ready_o),
    .cfg_data_bits_i(cfg_data_bits_i),
    .cfg_stop_bits_i(cfg_stop_bits_i),
    .cfg_parity_en_i(cfg_parity_en_i),
    .cfg_done_o     (cfg_done_o),
    .cfg_err_o      (cfg_err_o),
    .tx_busy_i      (tx_busy_i),
    .rx_busy_i      (rx_busy_i),
    .tx_hold_o      (tx_hold_o),
    .uart_cfg_o     (uart_cfg_o),
    .cfg_update_o   (cfg_update_o)
  );

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_cfg(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one request for a single cycle; returns one cycle after acceptance.
  task automatic send(input logic [3:0] d, input logic [1:0] s, input logic p,
                      input logic push, input resp_t exp);
    chk_bit("ready_before_accept", cfg_ready_o, 1'b1);
    cfg_valid_i     = 1'b1;
    cfg_data_bits_i = d;
    cfg_stop_bits_i = s;
    cfg_parity_en_i = p;
    if (push) exp_q.push_back(exp);
    tick();
    cfg_valid_i = 1'b0;
    chk_bit("ready_in_check", cfg_ready_o, 1'b0);
    chk_bit("hold_in_check", tx_hold_o, 1'b0);
  endtask

  task automatic pop_check(input string tag);
    resp_t e;
    chk_bit({tag, "_done"}, cfg_done_o, 1'b1);
    chk_bit({tag, "_sb_nonempty"}, exp_q.size() != 0, 1'b1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk_bit({tag, "_err"}, cfg_err_o, e.err);
      chk_cfg({tag, "_cfg"}, uart_cfg_o, e.cfg);
    end
  endtask

  initial begin
    rst_ni          = 1'b0;
    cfg_valid_i     = 1'b0;
    cfg_data_bits_i = 4'd0;
    cfg_stop_bits_i = 2'd0;
    cfg_parity_en_i = 1'b0;
    tx_busy_i       = 1'b0;
    rx_busy_i       = 1'b0;
    tick();
    tick();
    chk_cfg("rst_cfg", uart_cfg_o, 5'b11000);
    chk_bit("rst_ready", cfg_ready_o, 1'b1);
    chk_bit("rst_hold", tx_hold_o, 1'b0);
    chk_bit("rst_update", cfg_update_o, 1'b0);
    chk_bit("rst_done", cfg_done_o, 1'b0);
    chk_bit("rst_err", cfg_err_o, 1'b0);
    rst_ni = 1'b1;
    tick();

    // 7E2-style request with idle lines: DRAIN N+2..N+3, APPLY N+4, done N+5.
    send(4'd7, 2'd2, 1'b1, 1'b1, {1'b0, 5'b10011});
    chk_bit("n1_update", cfg_update_o, 1'b0);
    tick();
    chk_bit("n2_hold", tx_hold_o, 1'b1);
    chk_cfg("n2_cfg_old", uart_cfg_o, 5'b11000);
    tick();
    chk_bit("n3_hold", tx_hold_o, 1'b1);
    chk_bit("n3_update", cfg_update_o, 1'b0);
    tick();
    chk_bit("n4_update", cfg_update_o, 1'b1);
    chk_bit("n4_hold", tx_hold_o, 1'b1);
    chk_cfg("n4_cfg", uart_cfg_o, 5'b10011);
    tick();
    pop_check("apply_resp");
    chk_bit("n5_hold", tx_hold_o, 1'b0);
    chk_bit("n5_update", cfg_update_o, 1'b0);
    tick();
    chk_bit("n6_done", cfg_done_o, 1'b0);

    // Illegal data width, illegal stop count, out-of-range data, identical request.
    send(4'd4, 2'd2, 1'b0, 1'b1, {1'b1, 5'b10011});
    tick();
    pop_check("rej_data4");
    chk_bit("rej_data4_hold", tx_hold_o, 1'b0);
    chk_bit("rej_data4_update", cfg_update_o, 1'b0);
    tick();
    send(4'd8, 2'd0, 1'b1, 1'b1, {1'b1, 5'b10011});
    tick();
    pop_check("rej_stop0");
    chk_bit("rej_stop0_hold", tx_hold_o, 1'b0);
    tick();
    send(4'd9, 2'd1, 1'b0, 1'b1, {1'b1, 5'b10011});
    tick();
    pop_check("rej_data9");
    tick();
    send(4'd7, 2'd2, 1'b1, 1'b1, {1'b0, 5'b10011});
    tick();
    pop_check("same_cfg");
    chk_bit("same_cfg_update", cfg_update_o, 1'b0);
    chk_bit("same_cfg_hold", tx_hold_o, 1'b0);
    tick();

    // Busy Tx for 10 DRAIN cycles, one idle, one Rx-busy, then two idle cycles.
    tx_busy_i = 1'b1;
    send(4'd5, 2'd1, 1'b0, 1'b1, {1'b0, 5'b00000});
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_bit("busy_hold", tx_hold_o, 1'b1);
      chk_bit("busy_update", cfg_update_o, 1'b0);
    end
    tick();
    tx_busy_i = 1'b0;
    chk_bit("gap_update", cfg_update_o, 1'b0);
    tick();
    rx_busy_i = 1'b1;
    chk_bit("rxb_update", cfg_update_o, 1'b0);
    tick();
    rx_busy_i = 1'b0;
    chk_bit("idle1_update", cfg_update_o, 1'b0);
    tick();
    chk_bit("idle2_update", cfg_update_o, 1'b0);
    chk_bit("idle2_hold", tx_hold_o, 1'b1);
    tick();
    chk_bit("settle_apply_update", cfg_update_o, 1'b1);
    chk_cfg("settle_apply_cfg", uart_cfg_o, 5'b00000);
    tick();
    pop_check("settle_resp");
    tick();

    // Tx stuck busy: timeout after 16 DRAIN cycles, configuration unchanged.
    tx_busy_i = 1'b1;
    send(4'd6, 2'd3, 1'b1, 1'b1, {1'b1, 5'b00000});
    for (int i = 0; i < 16; i++) begin
      tick();
      chk_bit("to_hold", tx_hold_o, 1'b1);
      chk_bit("to_update", cfg_update_o, 1'b0);
      chk_bit("to_done_early", cfg_done_o, 1'b0);
    end
    tick();
    pop_check("timeout_resp");
    chk_bit("timeout_hold", tx_hold_o, 1'b0);
    tx_busy_i = 1'b0;
    tick();
    chk_bit("timeout_ready", cfg_ready_o, 1'b1);

    // Reset in DRAIN abandons the request and restores 8N1.
    tx_busy_i = 1'b1;
    send(4'd6, 2'd1, 1'b0, 1'b0, {1'b0, 5'b00000});
    tick();
    chk_bit("pre_rst_hold", tx_hold_o, 1'b1);
    rst_ni = 1'b0;
    tick();
    chk_bit("mid_rst_ready", cfg_ready_o, 1'b1);
    chk_cfg("mid_rst_cfg", uart_cfg_o, 5'b11000);
    chk_bit("mid_rst_hold", tx_hold_o, 1'b0);
    chk_bit("mid_rst_done", cfg_done_o, 1'b0);
    rst_ni    = 1'b1;
    tx_busy_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_bit("post_rst_done", cfg_done_o, 1'b0);
      chk_bit("post_rst_update", cfg_update_o, 1'b0);
    end
    chk_bit("sb_drained", exp_q.size() == 0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
